// File: rtl/cga_intr_level_sched_if.sv
// Signal bundle between the CGA level scheduler and its CPU / request-cell side.
// The master modport drives requests and writes; the slave modport is the scheduler.
interface cga_intr_level_sched_if #(
    parameter int unsigned LEVELS = 16,
    parameter int unsigned LVL_W  = 4
);
    logic              ION;
    logic [LEVELS-1:0] IRQ_SET;
    logic              PID_WR;
    logic              PIE_WR;
    logic [LEVELS-1:0] WDATA;
    logic              EXIT;
    logic              CHG_ACK;
    logic [LEVELS-1:0] PID;
    logic [LEVELS-1:0] PIE;
    logic [LVL_W-1:0]  PIL;
    logic              CHG_REQ;
    logic [LVL_W-1:0]  CHG_LVL;

    modport master (
        output ION, IRQ_SET, PID_WR, PIE_WR, WDATA, EXIT, CHG_ACK,
        input  PID, PIE, PIL, CHG_REQ, CHG_LVL
    );

    modport slave (
        input  ION, IRQ_SET, PID_WR, PIE_WR, WDATA, EXIT, CHG_ACK,
        output PID, PIE, PIL, CHG_REQ, CHG_LVL
    );
endinterface

// File: rtl/cga_intr_level_sched.sv
// CGA interrupt priority-level scheduler: PID/PIE registers, highest-level arbitration
// above PIL, and the REQ/ACK level-change handshake with the CPU microcode.
module cga_intr_level_sched #(
    parameter int unsigned LEVELS = 16,
    parameter int unsigned LVL_W  = 4
) (
    input  logic                    CP,
    input  logic                    CLR,
    cga_intr_level_sched_if.slave   bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]        state;
    logic [LEVELS-1:0] pid_q;
    logic [LEVELS-1:0] pie_q;
    logic [LVL_W-1:0]  pil_q;
    logic [LVL_W-1:0]  lvl_q;

    logic [LEVELS-1:0] pend;
    logic [LVL_W-1:0]  best;
    logic              win;
    logic              exit_acc;
    logic [LEVELS-1:0] pid_next;

    assign pend = pid_q & pie_q;

    always_comb begin
        best = '0;
        for (int unsigned i = 0; i < LEVELS; i++) begin
            if (pend[i]) best = LVL_W'(i);
        end
    end

    // best is 0 when nothing is pending, so level 0 can never beat PIL.
    assign win = bus.ION && (best > pil_q);

    // An ACK in REQ takes priority over a simultaneous EXIT.
    assign exit_acc = bus.EXIT && !(state == REQ && bus.CHG_ACK);

    // Set strobes are OR-ed in last so they win over both a write and an exit-clear.
    always_comb begin
        pid_next = bus.PID_WR ? bus.WDATA : pid_q;
        if (exit_acc && (pil_q != '0)) pid_next[pil_q] = 1'b0;
        pid_next = pid_next | bus.IRQ_SET;
    end

    always_ff @(posedge CP) begin
        if (CLR) begin
            pid_q <= '0;
            pie_q <= '0;
            pil_q <= '0;
            lvl_q <= '0;
            state <= IDLE;
        end else begin
            pid_q <= pid_next;
            if (bus.PIE_WR) pie_q <= bus.WDATA;

            case (state)
                IDLE: begin
                    if (bus.EXIT) begin
                        pil_q <= '0;
                    end else if (win) begin
                        lvl_q <= best;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.CHG_ACK) begin
                        pil_q <= lvl_q;
                        state <= IDLE;
                    end else if (bus.EXIT) begin
                        pil_q <= '0;
                        state <= IDLE;
                    end else if (!win) begin
                        state <= IDLE;
                    end else begin
                        lvl_q <= best;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.PID     = pid_q;
    assign bus.PIE     = pie_q;
    assign bus.PIL     = pil_q;
    assign bus.CHG_REQ = (state == REQ);
    assign bus.CHG_LVL = lvl_q;
endmodule

// File: tb/tb_cga_intr_level_sched.sv
// Scoreboard bench for cga_intr_level_sched: directed stimulus pushes expected
// register snapshots and handshake events; a negedge monitor pops and compares.
module tb_cga_intr_level_sched;
    logic CP  = 1'b0;
    logic CLR = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    cga_intr_level_sched_if #(.LEVELS(16), .LVL_W(4)) bus ();

    cga_intr_level_sched #(.LEVELS(16), .LVL_W(4)) dut (
        .CP  (CP),
        .CLR (CLR),
        .bus (bus.slave)
    );

    always #5 CP = ~CP;
    always @(posedge CP) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] pid;
        logic [15:0] pie;
        logic [3:0]  pil;
        logic        req;
        logic        lvl_chk;
        logic [3:0]  lvl;
    } snap_t;

    snap_t      snap_q[$];
    logic [3:0] req_q[$];
    logic [3:0] ack_q[$];

    function automatic void check(input string name, input int act, input int exp_v);
        checks++;
        if (act == exp_v) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    endfunction

    // Monitor: compares snapshots due this cycle, each new request, and each accepted ACK.
    logic prev_req = 1'b0;
    always @(negedge CP) begin
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            snap_t s;
            s = snap_q.pop_front();
            check("snap_cycle", s.cyc, cyc);
            check("PID", int'(bus.PID), int'(s.pid));
            check("PIE", int'(bus.PIE), int'(s.pie));
            check("PIL", int'(bus.PIL), int'(s.pil));
            check("CHG_REQ", int'(bus.CHG_REQ), int'(s.req));
            if (s.lvl_chk) check("CHG_LVL", int'(bus.CHG_LVL), int'(s.lvl));
        end
        if (bus.CHG_REQ && !prev_req) begin
            if (req_q.size() == 0) check("unexpected_req", int'(bus.CHG_LVL), -1);
            else check("req_lvl", int'(bus.CHG_LVL), int'(req_q.pop_front()));
        end
        if (bus.CHG_REQ && bus.CHG_ACK && !CLR) begin
            if (ack_q.size() == 0) check("unexpected_ack", int'(bus.CHG_LVL), -1);
            else check("ack_lvl", int'(bus.CHG_LVL), int'(ack_q.pop_front()));
        end
        prev_req = bus.CHG_REQ;
    end

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic expect_snap(input logic [15:0] pid, input logic [15:0] pie,
                               input logic [3:0] pil, input logic req,
                               input logic lvl_chk, input logic [3:0] lvl);
        snap_t s;
        s.cyc = cyc; s.pid = pid; s.pie = pie; s.pil = pil;
        s.req = req; s.lvl_chk = lvl_chk; s.lvl = lvl;
        snap_q.push_back(s);
    endtask

    function automatic logic [15:0] bitv(input int unsigned n);
        logic [15:0] one;
        one = 16'd1;
        return one << n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ION = 1'b0; bus.IRQ_SET = '0; bus.PID_WR = 1'b0; bus.PIE_WR = 1'b0;
        bus.WDATA = '0; bus.EXIT = 1'b0; bus.CHG_ACK = 1'b0;

        // Reset, then idle with ION=1 and everything enabled
        CLR = 1'b1;
        step(); step();
        CLR = 1'b0;
        expect_snap(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1, 4'd0);
        bus.ION = 1'b1; bus.PIE_WR = 1'b1; bus.WDATA = 16'hFFFF;
        step();
        bus.PIE_WR = 1'b0; bus.WDATA = '0;
        expect_snap(16'h0000, 16'hFFFF, 4'd0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            expect_snap(16'h0000, 16'hFFFF, 4'd0, 1'b0, 1'b0, 4'd0);
        end

        // Basic raise to level 10, then retarget to 13 before ACK
        bus.IRQ_SET = bitv(10);
        step();
        bus.IRQ_SET = '0;
        expect_snap(16'h0400, 16'hFFFF, 4'd0, 1'b0, 1'b0, 4'd0);
        req_q.push_back(4'd10);
        step();
        expect_snap(16'h0400, 16'hFFFF, 4'd0, 1'b1, 1'b1, 4'd10);
        bus.IRQ_SET = bitv(13);
        step();
        bus.IRQ_SET = '0;
        expect_snap(16'h2400, 16'hFFFF, 4'd0, 1'b1, 1'b1, 4'd10);
        step();
        expect_snap(16'h2400, 16'hFFFF, 4'd0, 1'b1, 1'b1, 4'd13);
        ack_q.push_back(4'd13);
        bus.CHG_ACK = 1'b1;
        step();
        bus.CHG_ACK = 1'b0;
        expect_snap(16'h2400, 16'hFFFF, 4'd13, 1'b0, 1'b0, 4'd0);
        step();
        expect_snap(16'h2400, 16'hFFFF, 4'd13, 1'b0, 1'b0, 4'd0);

        // Exit from 13 clears its bit; level 10 re-arbitrates two cycles later
        bus.EXIT = 1'b1;
        step();
        bus.EXIT = 1'b0;
        expect_snap(16'h0400, 16'hFFFF, 4'd0, 1'b0, 1'b0, 4'd0);
        req_q.push_back(4'd10);
        step();
        expect_snap(16'h0400, 16'hFFFF, 4'd0, 1'b1, 1'b1, 4'd10);
        ack_q.push_back(4'd10);
        bus.CHG_ACK = 1'b1;
        step();
        bus.CHG_ACK = 1'b0;
        expect_snap(16'h0400, 16'hFFFF, 4'd10, 1'b0, 1'b0, 4'd0);

        // Masking: only level 10 enabled, a level-12 strobe must not request
        bus.PIE_WR = 1'b1; bus.WDATA = 16'h0400;
        step();
        bus.PIE_WR = 1'b0; bus.WDATA = '0;
        expect_snap(16'h0400, 16'h0400, 4'd10, 1'b0, 1'b0, 4'd0);
        bus.IRQ_SET = bitv(12);
        step();
        bus.IRQ_SET = '0;
        expect_snap(16'h1400, 16'h0400, 4'd10, 1'b0, 1'b0, 4'd0);
        step(); step();
        expect_snap(16'h1400, 16'h0400, 4'd10, 1'b0, 1'b0, 4'd0);

        // ION gating: exit level 10, re-pend it with ION=0, then enable ION
        bus.ION = 1'b0; bus.EXIT = 1'b1;
        step();
        bus.EXIT = 1'b0;
        expect_snap(16'h1000, 16'h0400, 4'd0, 1'b0, 1'b0, 4'd0);
        bus.IRQ_SET = bitv(10);
        step();
        bus.IRQ_SET = '0;
        expect_snap(16'h1400, 16'h0400, 4'd0, 1'b0, 1'b0, 4'd0);
        step(); step(); step();
        expect_snap(16'h1400, 16'h0400, 4'd0, 1'b0, 1'b0, 4'd0);
        bus.ION = 1'b1;
        req_q.push_back(4'd10);
        step();
        expect_snap(16'h1400, 16'h0400, 4'd0, 1'b1, 1'b1, 4'd10);
        bus.ION = 1'b0;
        step();
        expect_snap(16'h1400, 16'h0400, 4'd0, 1'b0, 1'b0, 4'd0);
        bus.ION = 1'b1;
        req_q.push_back(4'd10);
        step();
        expect_snap(16'h1400, 16'h0400, 4'd0, 1'b1, 1'b1, 4'd10);
        ack_q.push_back(4'd10);
        bus.CHG_ACK = 1'b1;
        step();
        bus.CHG_ACK = 1'b0;
        expect_snap(16'h1400, 16'h0400, 4'd10, 1'b0, 1'b0, 4'd0);

        // EXIT and a set strobe on the same level: the strobe wins
        bus.EXIT = 1'b1; bus.IRQ_SET = bitv(10);
        step();
        bus.EXIT = 1'b0; bus.IRQ_SET = '0;
        expect_snap(16'h1400, 16'h0400, 4'd0, 1'b0, 1'b0, 4'd0);
        req_q.push_back(4'd10);
        step();
        expect_snap(16'h1400, 16'h0400, 4'd0, 1'b1, 1'b1, 4'd10);

        // EXIT while in REQ aborts the request, then it re-arbitrates
        bus.EXIT = 1'b1;
        step();
        bus.EXIT = 1'b0;
        expect_snap(16'h1400, 16'h0400, 4'd0, 1'b0, 1'b0, 4'd0);
        req_q.push_back(4'd10);
        step();
        expect_snap(16'h1400, 16'h0400, 4'd0, 1'b1, 1'b1, 4'd10);

        // Simultaneous PID/PIE write with a strobe; request retargets to 15
        bus.PID_WR = 1'b1; bus.PIE_WR = 1'b1; bus.WDATA = 16'h8001; bus.IRQ_SET = bitv(3);
        step();
        bus.PID_WR = 1'b0; bus.PIE_WR = 1'b0; bus.WDATA = '0; bus.IRQ_SET = '0;
        expect_snap(16'h8009, 16'h8001, 4'd0, 1'b1, 1'b1, 4'd10);
        step();
        expect_snap(16'h8009, 16'h8001, 4'd0, 1'b1, 1'b1, 4'd15);

        // Reset mid-handshake; the concurrent ACK must not land
        CLR = 1'b1; bus.CHG_ACK = 1'b1;
        step();
        CLR = 1'b0; bus.CHG_ACK = 1'b0;
        expect_snap(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1, 4'd0);

        // Back-to-back: ACK of 5 with a level-9 strobe in the same cycle
        bus.PIE_WR = 1'b1; bus.WDATA = 16'hFFFF; bus.IRQ_SET = bitv(5);
        step();
        bus.PIE_WR = 1'b0; bus.WDATA = '0; bus.IRQ_SET = '0;
        expect_snap(16'h0020, 16'hFFFF, 4'd0, 1'b0, 1'b0, 4'd0);
        req_q.push_back(4'd5);
        step();
        expect_snap(16'h0020, 16'hFFFF, 4'd0, 1'b1, 1'b1, 4'd5);
        ack_q.push_back(4'd5);
        bus.CHG_ACK = 1'b1; bus.IRQ_SET = bitv(9);
        step();
        bus.CHG_ACK = 1'b0; bus.IRQ_SET = '0;
        expect_snap(16'h0220, 16'hFFFF, 4'd5, 1'b0, 1'b0, 4'd0);
        req_q.push_back(4'd9);
        step();
        expect_snap(16'h0220, 16'hFFFF, 4'd5, 1'b1, 1'b1, 4'd9);
        ack_q.push_back(4'd9);
        bus.CHG_ACK = 1'b1;
        step();
        bus.CHG_ACK = 1'b0;
        expect_snap(16'h0220, 16'hFFFF, 4'd9, 1'b0, 1'b0, 4'd0);
        step(); step();
        expect_snap(16'h0220, 16'hFFFF, 4'd9, 1'b0, 1'b0, 4'd0);

        step(); step();
        check("snap_q_drained", snap_q.size(), 0);
        check("req_q_drained", req_q.size(), 0);
        check("ack_q_drained", ack_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
